// File: rtl/alu_pkg.sv
// Shared types and opcode helpers for the execute-stage ALU / RV32M unit.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,  OP_SUB    = 5'd1,  OP_AND    = 5'd2,  OP_OR     = 5'd3,
    OP_XOR    = 5'd4,  OP_SLL    = 5'd5,  OP_SRL    = 5'd6,  OP_SRA    = 5'd7,
    OP_GTU    = 5'd8,  OP_LTU    = 5'd9,  OP_LT     = 5'd10, OP_GE     = 5'd11,
    OP_MUL    = 5'd12, OP_MULH   = 5'd13, OP_MULHU  = 5'd14, OP_MULHSU = 5'd15,
    OP_DIV    = 5'd16, OP_DIVU   = 5'd17, OP_REM    = 5'd18, OP_REMU   = 5'd19,
    OP_ILL20  = 5'd20, OP_ILL21  = 5'd21, OP_ILL22  = 5'd22, OP_ILL23  = 5'd23,
    OP_ILL24  = 5'd24, OP_ILL25  = 5'd25, OP_ILL26  = 5'd26, OP_ILL27  = 5'd27,
    OP_ILL28  = 5'd28, OP_ILL29  = 5'd29, OP_ILL30  = 5'd30, OP_ILL31  = 5'd31
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  function automatic logic is_multicycle(alu_op_e op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  // Ops that interpret data1 as a two's-complement value.
  function automatic logic is_signed_op(alu_op_e op);
    return op inside {OP_LT, OP_GE, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative engine: shift-add multiply and restoring divide on operand magnitudes.
import alu_pkg::*;

module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] hi
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [XLEN-1:0] curHi, curLo, curOpnd;
  logic            div_q, div_d, curDiv;
  logic            busy_q, busy_d, done_q, done_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN:0]   mulSum, divShift, divDiff;

  // The first iteration runs on the freshly loaded operands in the start cycle.
  always_comb begin
    curDiv   = start ? (op >= OP_DIV) : div_q;
    curHi    = start ? '0 : hi_q;
    curLo    = start ? (curDiv ? a : b) : lo_q;
    curOpnd  = start ? (curDiv ? b : a) : opnd_q;
    mulSum   = {1'b0, curHi} + (curLo[0] ? {1'b0, curOpnd} : '0);
    divShift = {curHi, curLo[XLEN-1]};
    divDiff  = divShift - {1'b0, curOpnd};
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    if (flush) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start || busy_q) begin
      opnd_d = curOpnd;
      div_d  = curDiv;
      if (curDiv) begin
        if (!divDiff[XLEN]) begin
          hi_d = divDiff[XLEN-1:0];
          lo_d = {curLo[XLEN-2:0], 1'b1};
        end else begin
          hi_d = divShift[XLEN-1:0];
          lo_d = {curLo[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_d = mulSum[XLEN:1];
        lo_d = {mulSum[0], curLo[XLEN-1:1]};
      end
      if (start) begin
        busy_d = 1'b1;
        cnt_d  = '0;
      end else if (cnt_q == SHW'(XLEN-2)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        cnt_d  = SHW'(XLEN-1);
      end else begin
        cnt_d = cnt_q + SHW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lo   = lo_q;
  assign hi   = hi_q;

endmodule

// File: rtl/alu_muldiv.sv
// Handshaked execute-stage ALU with registered result and an iterative RV32M mul/div path.
import alu_pkg::*;

module alu_muldiv #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      sel,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  alu_op_e          op, op_q, op_d;
  state_e           state_q, state_d;
  logic [XLEN-1:0]  result_q, result_d, scResult, mdResult, magA, magB;
  logic             illegal_q, illegal_d, negProd_q, negProd_d, negRem_q, negRem_d;
  logic             accept, go, mcGo, isDiv, divZero, divOvf, isSpecial, illegalOp;
  logic             negA, negB, engBusy, engDone;
  logic [XLEN-1:0]  engLo, engHi;
  logic [2*XLEN-1:0] prod, prodFix;
  logic [SHW-1:0]   shamt;

  assign op        = alu_op_e'(sel);
  assign shamt     = data2[SHW-1:0];
  assign in_ready  = ~engBusy & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign go        = accept & ~flush;
  assign isDiv     = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign divZero   = (data2 == '0);
  assign divOvf    = ((op == OP_DIV) | (op == OP_REM)) & (data1 == MOST_NEG) & (data2 == '1);
  assign isSpecial = isDiv & (divZero | divOvf);
  assign mcGo      = is_multicycle(op) & ~isSpecial;
  assign illegalOp = (op > OP_REMU);
  assign negA      = is_signed_op(op) & data1[XLEN-1];
  assign negB      = (op inside {OP_MULH, OP_DIV, OP_REM}) & data2[XLEN-1];
  assign magA      = negA ? -data1 : data1;
  assign magB      = negB ? -data2 : data2;

  // Divide-by-zero and signed overflow resolve here so they never occupy the engine.
  always_comb begin
    scResult = '0;
    case (op)
      OP_ADD:  scResult = data1 + data2;
      OP_SUB:  scResult = data1 - data2;
      OP_AND:  scResult = data1 & data2;
      OP_OR:   scResult = data1 | data2;
      OP_XOR:  scResult = data1 ^ data2;
      OP_SLL:  scResult = data1 << shamt;
      OP_SRL:  scResult = data1 >> shamt;
      OP_SRA:  scResult = $unsigned($signed(data1) >>> shamt);
      OP_GTU:  scResult = {{(XLEN-1){1'b0}}, data1 > data2};
      OP_LTU:  scResult = {{(XLEN-1){1'b0}}, data1 < data2};
      OP_LT:   scResult = {{(XLEN-1){1'b0}}, $signed(data1) < $signed(data2)};
      OP_GE:   scResult = {{(XLEN-1){1'b0}}, $signed(data1) >= $signed(data2)};
      OP_DIV, OP_DIVU: scResult = divZero ? '1 : data1;
      OP_REM, OP_REMU: scResult = divZero ? data1 : '0;
      default: scResult = '0;
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .start (go & mcGo),
    .op    (op),
    .a     (magA),
    .b     (magB),
    .busy  (engBusy),
    .done  (engDone),
    .lo    (engLo),
    .hi    (engHi)
  );

  assign prod    = {engHi, engLo};
  assign prodFix = negProd_q ? -prod : prod;

  always_comb begin
    mdResult = '0;
    case (op_q)
      OP_MUL:                        mdResult = prodFix[XLEN-1:0];
      OP_MULH, OP_MULHU, OP_MULHSU:  mdResult = prodFix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               mdResult = negProd_q ? -engLo : engLo;
      OP_REM, OP_REMU:               mdResult = negRem_q ? -engHi : engHi;
      default:                       mdResult = '0;
    endcase
  end

  // flush wins over any accept or completion in the same cycle; result is kept.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    op_d      = op_q;
    negProd_d = negProd_q;
    negRem_d  = negRem_q;
    if (flush) begin
      state_d = IDLE;
    end else if (go) begin
      op_d      = op;
      negProd_d = negA ^ negB;
      negRem_d  = negA;
      if (mcGo) begin
        state_d   = BUSY;
        illegal_d = 1'b0;
      end else begin
        state_d   = DONE;
        result_d  = scResult;
        illegal_d = illegalOp;
      end
    end else begin
      case (state_q)
        BUSY: if (engDone) begin
          state_d  = DONE;
          result_d = mdResult;
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
      op_q      <= OP_ADD;
      negProd_q <= 1'b0;
      negRem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      op_q      <= op_d;
      negProd_q <= negProd_d;
      negRem_q  <= negRem_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed vectors push expectations, a monitor pops on handshake.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [4:0]  sel;
  logic [31:0] data1, data2, result;

  int assertCount = 0;
  int failCount   = 0;
  int cycleCnt    = 0;
  int lastAcceptCyc = 0;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t  sbQ[$];
  string nameQ[$];
  bit    headSeen = 0;

  alu_muldiv #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .data1     (data1),
    .data2     (data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Offers one op, holding it until the DUT samples it; latency is counted from the accept cycle.
  task automatic applyStimulus(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] e, input logic ill, input int lat,
                               input bit doPush, input string name);
    bit   wasReady;
    exp_t item;
    sel = s; data1 = a; data2 = b; in_valid = 1'b1;
    wasReady = 0;
    for (int i = 0; i < 200 && !wasReady; i++) begin
      @(negedge clk);
      wasReady = in_ready && rst_n && !flush;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!wasReady) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s accept: in_ready got 0 for 200 cycles, expected 1", name);
    end else begin
      lastAcceptCyc = cycleCnt - 1;
      if (doPush) begin
        item.res = e; item.ill = ill; item.lat = lat; item.acc = lastAcceptCyc;
        sbQ.push_back(item);
        nameQ.push_back(name);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sbQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected out_valid: got 1 with result 0x%08h, expected 0", result);
      end else begin
        if (!headSeen) begin
          checkOutput({nameQ[0], " latency"}, 32'(cycleCnt - sbQ[0].acc), 32'(sbQ[0].lat));
          headSeen = 1;
        end
        if (out_ready) begin
          checkOutput({nameQ[0], " result"}, result, sbQ[0].res);
          checkOutput({nameQ[0], " illegal"}, {31'b0, illegal}, {31'b0, sbQ[0].ill});
          void'(sbQ.pop_front());
          void'(nameQ.pop_front());
          headSeen = 0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int readyHigh, validSeen, firstAcc, riseCyc;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sel = '0; data1 = '0; data2 = '0;
    #1 rst_n = 1'b0;
    #11;
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset illegal", {31'b0, illegal}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    $display("[TB] multiply latency and stall");
    applyStimulus(5'd12, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, 1, "MUL 7*-3");
    readyHigh = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) readyHigh++;
    end
    checkOutput("MUL in_ready while busy", 32'(readyHigh), 32'd0);
    @(posedge clk); #1;

    $display("[TB] divide, special cases, single-cycle ops");
    applyStimulus(5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 1, "DIV -7/2");
    applyStimulus(5'd18, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 1, "REM -7%2");
    applyStimulus(5'd17, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 1, "DIVU 5/0");
    applyStimulus(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 1, "DIV ovf");
    applyStimulus(5'd18, 32'd5, 32'd0, 32'd5, 1'b0, 1, 1, "REM 5%0");
    applyStimulus(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 1, "REM ovf");
    applyStimulus(5'd17, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1, "DIVU 100/7");
    applyStimulus(5'd19, 32'd100, 32'd7, 32'd2, 1'b0, 33, 1, "REMU 100%7");
    applyStimulus(5'd16, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33, 1, "DIV 7/-2");
    applyStimulus(5'd18, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 33, 1, "REM 7%-2");
    applyStimulus(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 1, "MULH -1*-1");
    applyStimulus(5'd13, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 1, "MULH min*2");
    applyStimulus(5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, 1, "MULHSU");
    applyStimulus(5'd7, 32'hFFFF_FFF0, 32'h24, 32'hFFFF_FFFF, 1'b0, 1, 1, "SRA");
    applyStimulus(5'd10, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 1, "LT");
    applyStimulus(5'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 1, "GTU");
    applyStimulus(5'd11, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 1, "GE");
    applyStimulus(5'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 1, "LTU");
    applyStimulus(5'd5, 32'd1, 32'h3F, 32'h8000_0000, 1'b0, 1, 1, "SLL");
    applyStimulus(5'd6, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1, 1, "SRL");
    applyStimulus(5'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1, 1, "SUB");
    applyStimulus(5'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1, 1, "AND");
    applyStimulus(5'd3, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 1, 1, "OR");
    applyStimulus(5'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1, 1, "XOR");
    applyStimulus(5'd0, 32'd9, 32'd9, 32'd18, 1'b0, 1, 1, "ADD pre-illegal");
    applyStimulus(5'd25, 32'd9, 32'd9, 32'd0, 1'b1, 1, 1, "ILLEGAL 25");
    applyStimulus(5'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1, 1, "ADD clears illegal");

    $display("[TB] back-to-back throughput");
    firstAcc = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(5'd0, 32'(i), 32'h100, 32'(i) + 32'h100, 1'b0, 1, 1, "ADD b2b");
      if (i == 0) firstAcc = lastAcceptCyc;
    end
    checkOutput("b2b accept span", 32'(lastAcceptCyc - firstAcc), 32'd9);

    $display("[TB] output back-pressure");
    applyStimulus(5'd0, 32'h11, 32'h22, 32'h33, 1'b0, 1, 1, "ADD held");
    out_ready = 1'b0;
    riseCyc = 0;
    fork
      applyStimulus(5'd0, 32'h44, 32'h55, 32'h99, 1'b0, 1, 1, "ADD after stall");
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checkOutput("stall out_valid", {31'b0, out_valid}, 32'd1);
          checkOutput("stall result", result, 32'h33);
          checkOutput("stall in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        riseCyc = cycleCnt;
        out_ready = 1'b1;
      end
    join
    checkOutput("accept cycle vs out_ready rise", 32'(lastAcceptCyc), 32'(riseCyc));

    $display("[TB] MULHU and flush abort");
    applyStimulus(5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 1, "MULHU");
    applyStimulus(5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 0, "MULHU flushed");
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("flush in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("flush out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush result held", result, 32'hFFFF_FFFE);
    validSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) validSeen++;
    end
    checkOutput("flush no result", 32'(validSeen), 32'd0);
    @(posedge clk); #1;

    $display("[TB] reset abort");
    applyStimulus(5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 0, "MULHU reset");
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid-reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mid-reset result", result, 32'd0);
    checkOutput("mid-reset illegal", {31'b0, illegal}, 32'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) checkOutput("post-reset in_ready", {31'b0, in_ready}, 32'd1);
    validSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) validSeen++;
    end
    checkOutput("reset no result", 32'(validSeen), 32'd0);
    @(posedge clk); #1;
    applyStimulus(5'd0, 32'd5, 32'd6, 32'd11, 1'b0, 1, 1, "ADD after reset");

    for (int i = 0; i < 100 && sbQ.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
